// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32 write-back stage: load encodings,
// the hard-wired zero register index and the write-back FSM states.
package rv32_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] ZERO_ID = 5'd0;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  // x0 is hard-wired, so a write to it is silently dropped.
  function automatic logic writes_reg(input logic reg_we, input logic [4:0] rd_id);
    return reg_we && (rd_id != ZERO_ID);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Upstream handshake, data-memory response and register-file write port
// of the write-back stage. The stage is the slave; EX/MEM plus memory
// (or a bench) is the master.
interface wb_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd_id;
  logic        in_reg_we;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  out_W_id;
  logic        out_We;
  logic [31:0] out_W_data;
  logic        err_misaligned;
  logic        err_timeout;

  modport slave (
    input  in_valid, in_rd_id, in_reg_we, in_is_load, in_funct3, in_result,
    input  dmem_rvalid, dmem_rdata,
    output in_ready, out_W_id, out_We, out_W_data, err_misaligned, err_timeout
  );

  modport master (
    output in_valid, in_rd_id, in_reg_we, in_is_load, in_funct3, in_result,
    output dmem_rvalid, dmem_rdata,
    input  in_ready, out_W_id, out_We, out_W_data, err_misaligned, err_timeout
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: picks the byte/half at the given address
// out of the aligned word, extends it, and flags illegal loads.
module load_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result,
  output logic        illegal
);

  logic [31:0] shifted;

  // Little-endian lane select followed by sign/zero extension.
  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    result  = '0;
    illegal = 1'b0;
    case (funct3)
      F3_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU: result = {24'd0, shifted[7:0]};
      F3_LH: begin
        result  = {{16{shifted[15]}}, shifted[15:0]};
        illegal = addr[0];
      end
      F3_LHU: begin
        result  = {16'd0, shifted[15:0]};
        illegal = addr[0];
      end
      F3_LW: begin
        result  = rdata;
        illegal = (addr != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results with one-cycle latency and waits
// for data memory on loads, aborting a load that never gets a response.
//
//   state     | meaning
//   IDLE      | accepting instructions; ALU results written next cycle
//   WAIT_LOAD | legal load outstanding; upstream stalled until rvalid or timeout
module wb_stage
  import rv32_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  wb
);

  localparam logic [7:0] CNT_LAST = 8'(LOAD_TIMEOUT - 1);

  wb_state_e   state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        capture_en;

  logic [4:0]  ld_rd_id;
  logic        ld_reg_we;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr;

  logic [2:0]  al_funct3;
  logic [1:0]  al_addr;
  logic [31:0] al_result;
  logic        al_illegal;

  logic        we_q, we_nxt;
  logic [4:0]  id_q, id_nxt;
  logic [31:0] data_q, data_nxt;
  logic        mis_q, mis_nxt;
  logic        to_q, to_nxt;

  // Legality is judged on the incoming load; extraction on the captured one.
  assign al_funct3 = (state == IDLE) ? wb.in_funct3     : ld_funct3;
  assign al_addr   = (state == IDLE) ? wb.in_result[1:0] : ld_addr;

  load_align u_align (
    .funct3  (al_funct3),
    .addr    (al_addr),
    .rdata   (wb.dmem_rdata),
    .result  (al_result),
    .illegal (al_illegal)
  );

  assign wb.in_ready       = (state == IDLE);
  assign wb.out_We         = we_q;
  assign wb.out_W_id       = id_q;
  assign wb.out_W_data     = data_q;
  assign wb.err_misaligned = mis_q;
  assign wb.err_timeout    = to_q;

  // Next state, timeout counter and next values of the output registers.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture_en = 1'b0;
    we_nxt     = 1'b0;
    id_nxt     = id_q;
    data_nxt   = data_q;
    mis_nxt    = 1'b0;
    to_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (wb.in_valid) begin
          if (wb.in_is_load) begin
            if (al_illegal) begin
              mis_nxt = 1'b1;
            end else begin
              state_nxt  = WAIT_LOAD;
              cnt_nxt    = '0;
              capture_en = 1'b1;
            end
          end else if (writes_reg(wb.in_reg_we, wb.in_rd_id)) begin
            we_nxt   = 1'b1;
            id_nxt   = wb.in_rd_id;
            data_nxt = wb.in_result;
          end
        end
      end
      WAIT_LOAD: begin
        // A response on the final wait cycle still completes the load.
        if (wb.dmem_rvalid) begin
          state_nxt = IDLE;
          if (writes_reg(ld_reg_we, ld_rd_id)) begin
            we_nxt   = 1'b1;
            id_nxt   = ld_rd_id;
            data_nxt = al_result;
          end
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          to_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Attributes of the outstanding load, captured at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_rd_id  <= ZERO_ID;
      ld_reg_we <= 1'b0;
      ld_funct3 <= '0;
      ld_addr   <= '0;
    end else if (capture_en) begin
      ld_rd_id  <= wb.in_rd_id;
      ld_reg_we <= wb.in_reg_we;
      ld_funct3 <= wb.in_funct3;
      ld_addr   <= wb.in_result[1:0];
    end
  end

  // Registered write port and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      id_q   <= ZERO_ID;
      data_q <= '0;
      mis_q  <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      we_q   <= we_nxt;
      id_q   <= id_nxt;
      data_q <= data_nxt;
      mis_q  <= mis_nxt;
      to_q   <= to_nxt;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios followed by random traffic, all
// compared against a transaction-level reference model.
module tb_wb_stage;
  import rv32_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;

  wb_stage_if wb();

  wb_stage #(.LOAD_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: one pending load (if any) with its remaining wait budget.
  bit          m_known = 1'b0;
  bit          m_busy  = 1'b0;
  int          m_budget;
  logic [4:0]  m_rd;
  bit          m_we;
  logic [2:0]  m_f3;
  logic [1:0]  m_a;
  logic        e_we, e_mis, e_to;
  logic [4:0]  e_id;
  logic [31:0] e_data;

  function automatic bit ref_illegal(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return (int'(a) % 2) != 0;
      3'b010:         return a != 2'd0;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rdata);
    int unsigned w;
    int v;
    w = rdata / (32'd1 << (32'(a) * 8));
    v = 0;
    case (f3)
      3'b000: begin v = int'(w % 256);   if (v >= 128)   v = v - 256;   end
      3'b001: begin v = int'(w % 65536); if (v >= 32768) v = v - 65536; end
      3'b010: v = int'(rdata);
      3'b100: v = int'(w % 256);
      3'b101: v = int'(w % 65536);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic drive(input bit r, input bit v, input logic [4:0] rd, input bit we,
                       input bit ld, input logic [2:0] f3, input logic [31:0] res,
                       input bit rv, input logic [31:0] rdata);
    rst            = r;
    wb.in_valid    = v;
    wb.in_rd_id    = rd;
    wb.in_reg_we   = we;
    wb.in_is_load  = ld;
    wb.in_funct3   = f3;
    wb.in_result   = res;
    wb.dmem_rvalid = rv;
    wb.dmem_rdata  = rdata;
  endtask

  // Predict, clock once, compare.
  task automatic cycle();
    if (m_known)
      check("in_ready", 32'(wb.in_ready), 32'(!m_busy));
    e_we  = 1'b0;
    e_mis = 1'b0;
    e_to  = 1'b0;
    if (rst) begin
      m_known = 1'b1;
      m_busy  = 1'b0;
      e_id    = '0;
      e_data  = '0;
    end else if (!m_busy) begin
      if (wb.in_valid) begin
        if (wb.in_is_load) begin
          if (ref_illegal(wb.in_funct3, wb.in_result[1:0])) begin
            e_mis = 1'b1;
          end else begin
            m_busy   = 1'b1;
            m_budget = TMO;
            m_rd     = wb.in_rd_id;
            m_we     = wb.in_reg_we;
            m_f3     = wb.in_funct3;
            m_a      = wb.in_result[1:0];
          end
        end else if (wb.in_reg_we && wb.in_rd_id != 5'd0) begin
          e_we   = 1'b1;
          e_id   = wb.in_rd_id;
          e_data = wb.in_result;
        end
      end
    end else begin
      m_budget = m_budget - 1;
      if (wb.dmem_rvalid) begin
        m_busy = 1'b0;
        if (m_we && m_rd != 5'd0) begin
          e_we   = 1'b1;
          e_id   = m_rd;
          e_data = ref_load(m_f3, m_a, wb.dmem_rdata);
        end
      end else if (m_budget == 0) begin
        m_busy = 1'b0;
        e_to   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (m_known) begin
      check("out_We", 32'(wb.out_We), 32'(e_we));
      check("out_W_id", 32'(wb.out_W_id), 32'(e_id));
      check("out_W_data", wb.out_W_data, e_data);
      check("err_misaligned", 32'(wb.err_misaligned), 32'(e_mis));
      check("err_timeout", 32'(wb.err_timeout), 32'(e_to));
      check("pulse_exclusive",
            32'((32'(wb.out_We) + 32'(wb.err_misaligned) + 32'(wb.err_timeout)) <= 32'd1),
            32'd1);
    end
  endtask

  task automatic idle_cycle();
    drive(0, 0, 5'd0, 0, 0, 3'd0, 32'd0, 0, 32'd0);
    cycle();
  endtask

  initial begin
    drive(1, 0, 5'd0, 0, 0, 3'd0, 32'd0, 0, 32'd0);
    cycle();
    cycle();
    check("rst_we", 32'(wb.out_We), 32'd0);
    check("rst_id", 32'(wb.out_W_id), 32'd0);
    check("rst_data", wb.out_W_data, 32'd0);
    check("rst_ready", 32'(wb.in_ready), 32'd1);

    // Back-to-back ALU results.
    drive(0, 1, 5'd5, 1, 0, 3'd0, 32'h1234_5678, 0, 32'd0);
    cycle();
    check("alu_we", 32'(wb.out_We), 32'd1);
    check("alu_id", 32'(wb.out_W_id), 32'd5);
    check("alu_data", wb.out_W_data, 32'h1234_5678);
    drive(0, 1, 5'd6, 1, 0, 3'd0, 32'hCAFE_F00D, 0, 32'd0);
    cycle();
    check("alu2_id", 32'(wb.out_W_id), 32'd6);
    check("alu2_data", wb.out_W_data, 32'hCAFE_F00D);

    // LB at byte 3, response three cycles after acceptance.
    drive(0, 1, 5'd7, 1, 1, F3_LB, 32'h0000_1003, 0, 32'd0);
    cycle();
    check("lb_stall", 32'(wb.in_ready), 32'd0);
    idle_cycle();
    idle_cycle();
    check("lb_hold_id", 32'(wb.out_W_id), 32'd6);
    drive(0, 0, 5'd0, 0, 0, 3'd0, 32'd0, 1, 32'h80FF_0000);
    cycle();
    check("lb_we", 32'(wb.out_We), 32'd1);
    check("lb_data", wb.out_W_data, 32'hFFFF_FF80);

    // LHU at half 1.
    drive(0, 1, 5'd8, 1, 1, F3_LHU, 32'h0000_1002, 0, 32'd0);
    cycle();
    drive(0, 0, 5'd0, 0, 0, 3'd0, 32'd0, 1, 32'h80FF_0000);
    cycle();
    check("lhu_data", wb.out_W_data, 32'h0000_80FF);

    // Misaligned LW.
    drive(0, 1, 5'd9, 1, 1, F3_LW, 32'h0000_1002, 0, 32'd0);
    cycle();
    check("lw_mis", 32'(wb.err_misaligned), 32'd1);
    check("lw_mis_we", 32'(wb.out_We), 32'd0);
    check("lw_mis_ready", 32'(wb.in_ready), 32'd1);

    // Timeout after TMO wait cycles, then a stray late response.
    drive(0, 1, 5'd10, 1, 1, F3_LW, 32'h0000_0100, 0, 32'd0);
    cycle();
    for (int i = 0; i < TMO; i++) idle_cycle();
    check("tmo_pulse", 32'(wb.err_timeout), 32'd1);
    check("tmo_we", 32'(wb.out_We), 32'd0);
    check("tmo_ready", 32'(wb.in_ready), 32'd1);
    drive(0, 0, 5'd0, 0, 0, 3'd0, 32'd0, 1, 32'h5555_AAAA);
    cycle();
    check("late_rvalid_we", 32'(wb.out_We), 32'd0);

    // Load to x0 completes without a write.
    drive(0, 1, 5'd0, 1, 1, F3_LW, 32'h0000_0200, 0, 32'd0);
    cycle();
    drive(0, 0, 5'd0, 0, 0, 3'd0, 32'd0, 1, 32'hDEAD_BEEF);
    cycle();
    check("x0_we", 32'(wb.out_We), 32'd0);

    // Reset while waiting, then a response that must be discarded.
    drive(0, 1, 5'd11, 1, 1, F3_LB, 32'h0000_0300, 0, 32'd0);
    cycle();
    drive(1, 0, 5'd0, 0, 0, 3'd0, 32'd0, 1, 32'h0000_0012);
    cycle();
    drive(0, 0, 5'd0, 0, 0, 3'd0, 32'd0, 1, 32'h0000_0034);
    cycle();
    check("rstwait_we", 32'(wb.out_We), 32'd0);
    check("rstwait_data", wb.out_W_data, 32'd0);
    check("rstwait_id", 32'(wb.out_W_id), 32'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(99) == 0),
            ($urandom_range(9) < 6),
            ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)),
            ($urandom_range(3) != 0),
            ($urandom_range(1) == 1),
            3'($urandom_range(7)),
            $urandom,
            ($urandom_range(9) < 3),
            $urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
